// File: rtl/rom_page_loader.sv
// ROM download loader: paces ioctl bytes into SDRAM ROM pages against the refresh strobe,
// tracking per-page completion, overflow/protocol errors and end-of-download.
module rom_page_loader #(
   parameter int unsigned ADDR_W    = 25,
   parameter int unsigned RAM_AW    = 23,
   parameter int unsigned PAGE_BITS = 14,
   parameter int unsigned SLOTS     = 4,
   parameter int unsigned MODELS    = 2,
   parameter int unsigned BANK_W    = 2,
   parameter logic [SLOTS*(RAM_AW-PAGE_BITS)-1:0] PAGE_MAP = {9'h1ff, 9'h107, 9'h100, 9'h000}
) (
   input  logic                      clk_sys,
   input  logic                      reset,
   input  logic                      ce_ref,
   input  logic                      rom_download,
   input  logic                      ioctl_wr,
   input  logic [ADDR_W-1:0]         ioctl_addr,
   input  logic [7:0]                ioctl_dout,
   output logic                      ioctl_wait,
   output logic                      boot_wr,
   output logic [RAM_AW-1:0]         boot_a,
   output logic [BANK_W-1:0]         boot_bank,
   output logic [7:0]                boot_dout,
   output logic [MODELS*SLOTS-1:0]   loaded,
   output logic                      overflow,
   output logic                      proto_err,
   output logic                      done
);

   localparam int unsigned IDX_W  = ADDR_W - PAGE_BITS;
   localparam int unsigned PF_W   = RAM_AW - PAGE_BITS;
   localparam int unsigned NPAGES = MODELS * SLOTS;
   localparam int unsigned SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
   localparam int unsigned LD_W   = (NPAGES > 1) ? $clog2(NPAGES) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARM   = 2'd1,
      S_WRITE = 2'd2
   } state_e;

   // Page table unpacked from the parameter once, so slot lookup is a plain mux
   logic [PF_W-1:0] page_tbl [SLOTS];

   for (genvar s = 0; s < SLOTS; s++) begin : g_page_tbl
      assign page_tbl[s] = PAGE_MAP[s*PF_W +: PF_W];
   end

   logic [IDX_W-1:0]  idx_c;
   logic              in_range_c;
   logic [SLOT_W-1:0] slot_c;
   logic [BANK_W-1:0] model_c;
   logic [PF_W-1:0]   page_c;
   logic [LD_W-1:0]   pidx_c;

   assign idx_c      = ioctl_addr[ADDR_W-1:PAGE_BITS];
   assign in_range_c = 64'(idx_c) < 64'(NPAGES);
   assign slot_c     = SLOT_W'(idx_c % IDX_W'(SLOTS));
   assign model_c    = BANK_W'(idx_c / IDX_W'(SLOTS));
   assign page_c     = page_tbl[slot_c];
   assign pidx_c     = LD_W'(idx_c);

   state_e            state_q;
   logic              wait_q;
   logic              wr_q;
   logic [RAM_AW-1:0] a_q;
   logic [BANK_W-1:0] bank_q;
   logic [7:0]        dout_q;
   logic [LD_W-1:0]   pidx_q;
   logic [NPAGES-1:0] loaded_q;
   logic              ovf_q;
   logic              perr_q;
   logic              done_q;
   logic              dl_q;
   logic              window_q;

   // Loader FSM with all status and SDRAM-side outputs registered
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         wait_q   <= 1'b0;
         wr_q     <= 1'b0;
         a_q      <= '0;
         bank_q   <= '0;
         dout_q   <= '0;
         pidx_q   <= '0;
         loaded_q <= '0;
         ovf_q    <= 1'b0;
         perr_q   <= 1'b0;
         done_q   <= 1'b0;
         dl_q     <= 1'b0;
         window_q <= 1'b0;
      end else begin
         dl_q   <= rom_download;
         done_q <= 1'b0;

         // A fresh download window starts with clean status
         if (rom_download && !dl_q) begin
            loaded_q <= '0;
            ovf_q    <= 1'b0;
            perr_q   <= 1'b0;
         end

         // done waits for any in-flight byte to drain back to IDLE
         if (rom_download) begin
            window_q <= 1'b1;
         end else if (window_q && (state_q == S_IDLE)) begin
            window_q <= 1'b0;
            done_q   <= 1'b1;
         end

         case (state_q)
            S_IDLE: begin
               if (rom_download && ioctl_wr) begin
                  if (in_range_c) begin
                     a_q     <= {page_c, ioctl_addr[PAGE_BITS-1:0]};
                     bank_q  <= model_c;
                     dout_q  <= ioctl_dout;
                     pidx_q  <= pidx_c;
                     wait_q  <= 1'b1;
                     state_q <= S_ARM;
                  end else begin
                     ovf_q <= 1'b1;
                  end
               end
            end
            S_ARM: begin
               if (ioctl_wr) perr_q <= 1'b1;
               if (ce_ref) begin
                  wr_q    <= 1'b1;
                  state_q <= S_WRITE;
               end
            end
            S_WRITE: begin
               if (ioctl_wr) perr_q <= 1'b1;
               if (ce_ref) begin
                  wr_q    <= 1'b0;
                  wait_q  <= 1'b0;
                  state_q <= S_IDLE;
                  if (&a_q[PAGE_BITS-1:0]) loaded_q[pidx_q] <= 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign ioctl_wait = wait_q;
   assign boot_wr    = wr_q;
   assign boot_a     = a_q;
   assign boot_bank  = bank_q;
   assign boot_dout  = dout_q;
   assign loaded     = loaded_q;
   assign overflow   = ovf_q;
   assign proto_err  = perr_q;
   assign done       = done_q;

endmodule

// File: tb/tb_rom_page_loader.sv
// Bench for rom_page_loader: directed corner cases plus randomized byte writes,
// each transaction judged against an address/page model and latency bounds.
module tb_rom_page_loader;

   logic        clk_sys = 1'b0;
   logic        reset;
   logic        ce_ref;
   logic        rom_download;
   logic        ioctl_wr;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_dout;
   logic        ioctl_wait;
   logic        boot_wr;
   logic [22:0] boot_a;
   logic [1:0]  boot_bank;
   logic [7:0]  boot_dout;
   logic [7:0]  loaded;
   logic        overflow;
   logic        proto_err;
   logic        done;

   rom_page_loader dut (
      .clk_sys      (clk_sys),
      .reset        (reset),
      .ce_ref       (ce_ref),
      .rom_download (rom_download),
      .ioctl_wr     (ioctl_wr),
      .ioctl_addr   (ioctl_addr),
      .ioctl_dout   (ioctl_dout),
      .ioctl_wait   (ioctl_wait),
      .boot_wr      (boot_wr),
      .boot_a       (boot_a),
      .boot_bank    (boot_bank),
      .boot_dout    (boot_dout),
      .loaded       (loaded),
      .overflow     (overflow),
      .proto_err    (proto_err),
      .done         (done)
   );

   always #5 clk_sys = ~clk_sys;

   int unsigned page_map [4] = '{32'h000, 32'h100, 32'h107, 32'h1ff};
   int unsigned cep = 16;
   int unsigned ce_cnt = 0;
   logic [7:0]  exp_loaded = '0;
   logic        exp_ovf = 1'b0;
   logic        exp_perr = 1'b0;
   int          nvec = 0;
   int          nerr = 0;

   // Refresh strobe: one cycle high every cep cycles
   initial begin
      ce_ref = 1'b0;
      forever begin
         @(posedge clk_sys);
         #1;
         if (reset) begin
            ce_cnt = 0;
            ce_ref = 1'b0;
         end else begin
            ce_cnt++;
            if (ce_cnt >= cep) ce_cnt = 0;
            ce_ref = (ce_cnt == 0);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got hang expected finish");
      $fatal(1);
   end

   task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   function automatic logic [22:0] exp_a(input logic [24:0] addr);
      int unsigned idx;
      idx = 32'(addr >> 14);
      return 23'((page_map[idx % 4] << 14) | 32'(addr[13:0]));
   endfunction

   task automatic check_status(input string tag);
      expect_eq({tag, "_loaded"}, 64'(loaded), 64'(exp_loaded));
      expect_eq({tag, "_overflow"}, 64'(overflow), 64'(exp_ovf));
      expect_eq({tag, "_proto_err"}, 64'(proto_err), 64'(exp_perr));
   endtask

   // One byte strobe; dup repeats the strobe while busy, drop ends the window mid-write
   task automatic do_write(input logic [24:0] addr, input logic [7:0] data,
                           input bit dup, input bit drop);
      int unsigned idx;
      int unsigned p;
      int rises, rise_c, fall_c;
      logic prev, early_done, wait_lost, seen;
      idx = 32'(addr >> 14);
      p   = cep;
      ioctl_addr = addr;
      ioctl_dout = data;
      ioctl_wr   = 1'b1;
      tick();
      if (idx >= 8) begin
         ioctl_wr = 1'b0;
         exp_ovf  = 1'b1;
         seen = 1'b0;
         repeat (20) begin
            seen |= ioctl_wait | boot_wr;
            tick();
         end
         expect_eq("ovf_busy", 64'(seen), 64'(0));
         check_status("ovf");
         return;
      end
      expect_eq("wait_rise", 64'(ioctl_wait), 64'(1));
      if (dup) begin
         ioctl_dout = ~data;
         ioctl_addr = addr ^ 25'h1;
         exp_perr   = 1'b1;
      end else begin
         ioctl_wr = 1'b0;
      end
      rises = 0; rise_c = 0; fall_c = 0;
      prev = 1'b0; early_done = 1'b0; wait_lost = 1'b0;
      for (int c = 1; c <= 400 && fall_c == 0; c++) begin
         if (c == 2) ioctl_wr = 1'b0;
         if (boot_wr && !prev) begin
            rises++;
            rise_c = c;
            expect_eq("boot_a", 64'(boot_a), 64'(exp_a(addr)));
            expect_eq("boot_bank", 64'(boot_bank), 64'(idx / 4));
            expect_eq("boot_dout", 64'(boot_dout), 64'(data));
            if (drop) rom_download = 1'b0;
         end
         if (!boot_wr && prev) fall_c = c;
         else if (!ioctl_wait) wait_lost = 1'b1;
         early_done |= done;
         prev = boot_wr;
         if (fall_c == 0) tick();
      end
      expect_eq("fall_seen", 64'(fall_c != 0), 64'(1));
      expect_eq("wait_fall", 64'(ioctl_wait), 64'(0));
      expect_eq("wait_held", 64'(wait_lost), 64'(0));
      expect_eq("rise_latency_ok", 64'((rise_c - 1 >= 1) && (rise_c - 1 <= int'(p))), 64'(1));
      expect_eq("wr_width", 64'(fall_c - rise_c), 64'(p));
      expect_eq("wr_pulses", 64'(rises), 64'(1));
      expect_eq("done_while_busy", 64'(early_done), 64'(0));
      if (addr[13:0] == 14'h3fff) exp_loaded[idx] = 1'b1;
      check_status("wr");
   endtask

   initial begin
      int cnt;
      logic seen;
      logic [24:0] addr;
      reset = 1'b1;
      rom_download = 1'b0;
      ioctl_wr = 1'b0;
      ioctl_addr = '0;
      ioctl_dout = '0;
      repeat (3) tick();
      expect_eq("rst_wait", 64'(ioctl_wait), 64'(0));
      expect_eq("rst_boot_wr", 64'(boot_wr), 64'(0));
      expect_eq("rst_boot_a", 64'(boot_a), 64'(0));
      expect_eq("rst_boot_bank", 64'(boot_bank), 64'(0));
      expect_eq("rst_boot_dout", 64'(boot_dout), 64'(0));
      expect_eq("rst_done", 64'(done), 64'(0));
      check_status("rst");
      reset = 1'b0;
      tick();
      rom_download = 1'b1;
      repeat (2) tick();

      do_write(25'h0000000, 8'hA5, 1'b0, 1'b0);
      do_write(25'h0016123, 8'h3C, 1'b0, 1'b0);
      do_write(25'h0003FFF, 8'h11, 1'b0, 1'b0);
      do_write(25'h0007FFF, 8'h22, 1'b0, 1'b0);
      do_write(25'h0020000, 8'h33, 1'b0, 1'b0);
      do_write(25'h0008004, 8'h44, 1'b1, 1'b0);
      do_write(25'h001C010, 8'h55, 1'b0, 1'b1);

      cnt = 0;
      repeat (30) begin
         cnt += int'(done);
         tick();
      end
      expect_eq("done_once", 64'(cnt), 64'(1));

      // Strobe outside a download window is ignored
      ioctl_addr = 25'h0;
      ioctl_wr = 1'b1;
      tick();
      ioctl_wr = 1'b0;
      seen = 1'b0;
      repeat (20) begin
         seen |= ioctl_wait | boot_wr | done;
         tick();
      end
      expect_eq("idle_wr_ignored", 64'(seen), 64'(0));
      check_status("closed");

      rom_download = 1'b1;
      repeat (2) tick();
      exp_loaded = '0;
      exp_ovf = 1'b0;
      exp_perr = 1'b0;
      check_status("reopen");

      // Reset landing inside a write
      do_write(25'h0003FFF, 8'h66, 1'b0, 1'b0);
      ioctl_addr = 25'h0004000;
      ioctl_dout = 8'h77;
      ioctl_wr = 1'b1;
      tick();
      ioctl_wr = 1'b0;
      for (int c = 0; c < 100 && !boot_wr; c++) tick();
      expect_eq("pre_rst_wr", 64'(boot_wr), 64'(1));
      #3 reset = 1'b1;
      #1;
      expect_eq("async_rst_wr", 64'(boot_wr), 64'(0));
      expect_eq("async_rst_wait", 64'(ioctl_wait), 64'(0));
      exp_loaded = '0;
      exp_ovf = 1'b0;
      exp_perr = 1'b0;
      check_status("async_rst");
      @(posedge clk_sys);
      #1 reset = 1'b0;
      tick();
      do_write(25'h0004000, 8'h5A, 1'b0, 1'b0);

      for (int i = 0; i < 40; i++) begin
         cep = $urandom_range(1, 9);
         repeat ($urandom_range(1, 3)) tick();
         if ($urandom_range(0, 7) == 0) begin
            addr = {11'($urandom_range(8, 2047)), 14'($urandom)};
         end else begin
            addr = {11'($urandom_range(0, 7)), 14'($urandom)};
            if ($urandom_range(0, 3) == 0) addr[13:0] = 14'h3fff;
         end
         do_write(addr, 8'($urandom), 1'b0, 1'b0);
      end

      rom_download = 1'b0;
      cnt = 0;
      repeat (30) begin
         cnt += int'(done);
         tick();
      end
      expect_eq("final_done_once", 64'(cnt), 64'(1));

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
